// File: rtl/dec3_8_pulse.sv
// Registered 3-to-8 decoder that stretches each accepted code into a
// PULSE_LEN-cycle one-hot strobe and then holds the outputs low for one gap cycle.
module dec3_8_pulse #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] code,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] out,
  output logic       busy,
  output logic       overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // A zero length behaves as a single-cycle pulse.
  localparam int unsigned     LEN_EFF  = (PULSE_LEN == 0) ? 1 : PULSE_LEN;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LEN_EFF - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;

  assign ready = en & (state == IDLE) & ~rst;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out     <= '0;
      counter <= '0;
      overrun <= 1'b0;
    end else if (!en) begin
      // Disable aborts immediately, skipping the gap cycle.
      state   <= IDLE;
      out     <= '0;
      counter <= '0;
      overrun <= 1'b0;
    end else begin
      if (valid && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          out <= '0;
          if (valid) begin
            state   <= PULSE;
            out     <= 8'b1 << code;
            counter <= CNT_LOAD;
          end
        end
        PULSE: begin
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else begin
            state <= GAP;
            out   <= '0;
          end
        end
        GAP: begin
          state <= IDLE;
          out   <= '0;
        end
        default: begin
          state   <= IDLE;
          out     <= '0;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec3_8_pulse.sv
// Directed bench for dec3_8_pulse: a PULSE_LEN=4 instance and a PULSE_LEN=1
// instance, with expected strobe sequences queued as codes are offered.
module tb_dec3_8_pulse;

  logic       clk = 1'b0;
  logic       rst, en, valid;
  logic [2:0] code;
  logic       ready, busy, overrun;
  logic [7:0] out;

  logic       rst1, en1, valid1;
  logic [2:0] code1;
  logic       ready1, busy1, overrun1;
  logic [7:0] out1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  dec3_8_pulse #(.PULSE_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .code(code), .valid(valid),
    .ready(ready), .out(out), .busy(busy), .overrun(overrun)
  );

  dec3_8_pulse #(.PULSE_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .code(code1), .valid(valid1),
    .ready(ready1), .out(out1), .busy(busy1), .overrun(overrun1)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back(v);
  endtask

  task automatic chk_sb(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed %02h expected queued value, queue empty", tag, obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk8(tag, obs, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; code = 3'd0;
    rst1 = 1'b1; en1 = 1'b1; valid1 = 1'b0; code1 = 3'd0;

    // Reset
    tick();
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_out", out, 8'h00);
    chk1("rst_overrun", overrun, 1'b0);
    chk8("rst_out1", out1, 8'h00);
    tick();
    rst = 1'b0; rst1 = 1'b0;
    #1;
    chk1("idle_ready", ready, 1'b1);

    // Single accept, code 5
    code = 3'd5; valid = 1'b1;
    tick();
    valid = 1'b0; code = 3'd0;
    push(8'h20, 4); push(8'h00, 1);
    for (int i = 1; i <= 5; i++) begin
      chk_sb("single_out", out);
      chk1("single_ready", ready, 1'b0);
      chk1("single_busy", busy, 1'b1);
      tick();
    end
    chk1("single_ready_back", ready, 1'b1);
    chk1("single_busy_done", busy, 1'b0);
    chk8("single_out_idle", out, 8'h00);

    // Back-to-back codes 0 then 7 with valid held
    code = 3'd0; valid = 1'b1;
    tick();
    code = 3'd7;
    push(8'h01, 4); push(8'h00, 2); push(8'h80, 4); push(8'h00, 1);
    for (int i = 1; i <= 11; i++) begin
      chk_sb("b2b_out", out);
      if (i == 1) chk1("b2b_overrun_pre", overrun, 1'b0);
      if (i == 2) chk1("b2b_overrun_set", overrun, 1'b1);
      if (i == 5) chk1("b2b_ready_gap", ready, 1'b0);
      if (i == 6) chk1("b2b_ready_idle", ready, 1'b1);
      tick();
      if (i == 6) valid = 1'b0;
    end
    chk1("b2b_ready_end", ready, 1'b1);
    chk1("b2b_overrun_held", overrun, 1'b1);

    // Abort by dropping en in the second pulse cycle
    code = 3'd2; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk8("abort_out_p1", out, 8'h04);
    chk1("abort_overrun_pre", overrun, 1'b1);
    tick();
    chk8("abort_out_p2", out, 8'h04);
    en = 1'b0;
    #1;
    chk1("abort_ready_en0", ready, 1'b0);
    tick();
    chk8("abort_out", out, 8'h00);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_overrun", overrun, 1'b0);
    chk1("abort_ready", ready, 1'b0);
    tick();
    chk8("abort_out_hold", out, 8'h00);
    chk1("abort_busy_hold", busy, 1'b0);
    chk1("abort_ready_hold", ready, 1'b0);
    en = 1'b1;
    #1;
    chk1("abort_ready_en1", ready, 1'b1);

    // Reset in the third pulse cycle
    code = 3'd6; valid = 1'b1;
    tick();
    chk8("rstmid_out_p1", out, 8'h40);
    tick();
    valid = 1'b0;
    chk8("rstmid_out_p2", out, 8'h40);
    chk1("rstmid_overrun_pre", overrun, 1'b1);
    tick();
    chk8("rstmid_out_p3", out, 8'h40);
    rst = 1'b1;
    #1;
    chk1("rstmid_ready_rst", ready, 1'b0);
    tick();
    chk8("rstmid_out", out, 8'h00);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_overrun", overrun, 1'b0);
    chk1("rstmid_ready", ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rstmid_ready_rel", ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk8("rstmid_no_residual", out, 8'h00);
      chk1("rstmid_busy_after", busy, 1'b0);
    end

    // Disabled input
    en = 1'b0; valid = 1'b1; code = 3'd4;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk8("dis_out", out, 8'h00);
      chk1("dis_ready", ready, 1'b0);
      chk1("dis_busy", busy, 1'b0);
      chk1("dis_overrun", overrun, 1'b0);
    end
    valid = 1'b0; en = 1'b1;

    // PULSE_LEN=1: all codes at full rate
    valid1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << k;
      code1 = 3'(k);
      #1;
      chk1("p1_ready", ready1, 1'b1);
      chk8("p1_out_idle", out1, 8'h00);
      push(oh, 1); push(8'h00, 1);
      tick();
      chk_sb("p1_out_pulse", out1);
      chk1("p1_busy", busy1, 1'b1);
      chk1("p1_onehot", ($countones(out1) == 1), 1'b1);
      tick();
      chk_sb("p1_out_gap", out1);
      chk1("p1_ready_gap", ready1, 1'b0);
      tick();
    end
    valid1 = 1'b0;
    chk1("p1_overrun", overrun1, 1'b1);
    chk1("sb_drained", (sb.size() == 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
